// File: rtl/sobel_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ==================================================================
// Module : sobel_pkg
// Shared constants and types for the sobel read-DMA path.
// Rev    : 1.0
// ==================================================================
package sobel_pkg;

    localparam logic [31:0] HC_CONTROL_START = 32'h0000_0001;
    localparam int          HC_CL_BYTES      = 64;
    localparam int          HC_CL_SHIFT      = $clog2(HC_CL_BYTES);
    // A 32-bit byte size rounds up to at most 2^26 lines, so 27 bits suffice.
    localparam int          RD_CNT_W         = 27;

    typedef logic [41:0] t_hc_cl_addr;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_rd_state;

    // Round a byte count up to whole cachelines; the 33-bit sum keeps 0xFFFF_FFFF exact.
    function automatic logic [RD_CNT_W-1:0] lines_for_size(input logic [31:0] size);
        logic [32:0] w_sum;
        w_sum = {1'b0, size} + 33'(HC_CL_BYTES - 1);
        return RD_CNT_W'(w_sum >> HC_CL_SHIFT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_rd_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ==================================================================
// Module : sobel_rd_engine
// Read-DMA: one cacheline request per 64-byte line, tags returned lines.
// Rev    : 1.0
// ==================================================================
module sobel_rd_engine
    import sobel_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int MDATA_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        hc_control,
    input  logic [41:0]        hc_buf_addr,
    input  logic [31:0]        hc_buf_size,
    input  logic               rd_req_almfull,
    output logic               rd_req_valid,
    output logic [41:0]        rd_req_addr,
    output logic [MDATA_W-1:0] rd_req_mdata,
    input  logic               rd_rsp_valid,
    input  logic [MDATA_W-1:0] rd_rsp_mdata,
    input  logic [511:0]       rd_rsp_data,
    output logic               line_valid,
    output logic [511:0]       line_data,
    output logic [MDATA_W-1:0] line_idx,
    output logic               busy,
    output logic               done,
    output logic               complete
);

    t_rd_state             r_state;
    t_rd_state             w_state_nxt;
    logic [31:0]           r_ctrl_q;
    logic [RD_CNT_W-1:0]   r_total;
    logic [RD_CNT_W-1:0]   r_issued;
    logic [RD_CNT_W-1:0]   r_received;
    t_hc_cl_addr           r_next_addr;

    logic                  r_req_valid;
    t_hc_cl_addr           r_req_addr;
    logic [MDATA_W-1:0]    r_req_mdata;
    logic                  r_line_valid;
    logic [511:0]          r_line_data;
    logic [MDATA_W-1:0]    r_line_idx;
    logic                  r_complete;

    logic                  w_busy;
    logic                  w_start;
    logic                  w_issue;
    logic                  w_accept;
    logic [RD_CNT_W-1:0]   w_total_new;
    logic [RD_CNT_W-1:0]   w_inflight;

    assign w_busy      = (r_state == REQ) || (r_state == DRAIN);
    assign w_start     = (hc_control == HC_CONTROL_START) && (r_ctrl_q != hc_control) &&
                         ((r_state == IDLE) || (r_state == DONE));
    assign w_total_new = lines_for_size(hc_buf_size);
    assign w_inflight  = r_issued - r_received;
    assign w_issue     = (r_state == REQ) && !rd_req_almfull && (r_issued < r_total) &&
                         (w_inflight < RD_CNT_W'(MAX_OUTSTANDING));
    assign w_accept    = rd_rsp_valid && w_busy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = (w_total_new == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (r_issued == r_total) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_received == r_total) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // A start landing in the done cycle is honoured rather than lost.
                if (w_start) begin
                    w_state_nxt = (w_total_new == '0) ? DONE : REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_ctrl_q     <= '0;
            r_total      <= '0;
            r_issued     <= '0;
            r_received   <= '0;
            r_next_addr  <= '0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= '0;
            r_req_mdata  <= '0;
            r_line_valid <= 1'b0;
            r_line_data  <= '0;
            r_line_idx   <= '0;
            r_complete   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ctrl_q     <= hc_control;
            r_req_valid  <= w_issue;
            r_line_valid <= w_accept;

            if (w_start) begin
                r_total     <= w_total_new;
                r_next_addr <= hc_buf_addr;
                r_issued    <= '0;
                r_received  <= '0;
            end else begin
                if (w_issue) begin
                    r_next_addr <= r_next_addr + 42'd1;
                    r_issued    <= r_issued + 1'b1;
                end
                if (w_accept) begin
                    r_received <= r_received + 1'b1;
                end
            end

            if (w_issue) begin
                r_req_addr  <= r_next_addr;
                r_req_mdata <= MDATA_W'(r_issued);
            end

            if (w_accept) begin
                r_line_data <= rd_rsp_data;
                r_line_idx  <= rd_rsp_mdata;
            end

            if (w_state_nxt == DONE) begin
                r_complete <= 1'b1;
            end else if (w_start) begin
                r_complete <= 1'b0;
            end
        end
    end

    assign rd_req_valid = r_req_valid;
    assign rd_req_addr  = r_req_addr;
    assign rd_req_mdata = r_req_mdata;
    assign line_valid   = r_line_valid;
    assign line_data    = r_line_data;
    assign line_idx     = r_line_idx;
    assign busy         = w_busy;
    assign done         = (r_state == DONE);
    assign complete     = r_complete;

endmodule
`default_nettype wire

// File: tb/tb_sobel_rd_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ==================================================================
// Module : tb_sobel_rd_engine
// Randomised bench for sobel_rd_engine against a transfer-level model.
// Rev    : 1.0
// ==================================================================
module tb_sobel_rd_engine;

    localparam int MAXO = 4;
    localparam int MW   = 16;
    localparam int P_IDLE = 0, P_REQ = 1, P_DRAIN = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   hc_control = '0;
    logic [41:0]   hc_buf_addr = '0;
    logic [31:0]   hc_buf_size = '0;
    logic          rd_req_almfull = 1'b0;
    logic          rd_req_valid;
    logic [41:0]   rd_req_addr;
    logic [MW-1:0] rd_req_mdata;
    logic          rd_rsp_valid = 1'b0;
    logic [MW-1:0] rd_rsp_mdata = '0;
    logic [511:0]  rd_rsp_data = '0;
    logic          line_valid;
    logic [511:0]  line_data;
    logic [MW-1:0] line_idx;
    logic          busy;
    logic          done;
    logic          complete;

    sobel_rd_engine #(.MAX_OUTSTANDING(MAXO), .MDATA_W(MW)) dut (
        .clk(clk), .reset(reset), .hc_control(hc_control), .hc_buf_addr(hc_buf_addr),
        .hc_buf_size(hc_buf_size), .rd_req_almfull(rd_req_almfull),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .line_valid(line_valid), .line_data(line_data), .line_idx(line_idx),
        .busy(busy), .done(done), .complete(complete)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    int           m_phase = P_IDLE;
    longint       m_total = 0, m_issued = 0, m_recv = 0;
    logic [41:0]  m_next = '0;
    logic [31:0]  m_prev = '0;
    logic         e_req_valid = 0, e_line_valid = 0, e_complete = 0;
    logic [41:0]  e_req_addr = '0;
    logic [MW-1:0] e_req_mdata = '0, e_line_idx = '0;
    logic [511:0] e_line_data = '0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_phase = P_IDLE; m_total = 0; m_issued = 0; m_recv = 0; m_next = '0; m_prev = '0;
            e_req_valid = 0; e_line_valid = 0; e_complete = 0;
        end else begin
            bit     busy_now, start, issue, take;
            longint new_total;
            int     nxt;
            busy_now  = (m_phase == P_REQ) || (m_phase == P_DRAIN);
            start     = (hc_control == 32'h1) && (m_prev != hc_control) && !busy_now;
            new_total = (longint'(hc_buf_size) + 63) / 64;
            issue     = (m_phase == P_REQ) && !rd_req_almfull && (m_issued < m_total) &&
                        ((m_issued - m_recv) < MAXO);
            take      = rd_rsp_valid && busy_now;
            e_req_valid  = issue;
            e_line_valid = take;
            if (issue) begin
                e_req_addr  = m_next;
                e_req_mdata = MW'(m_issued);
            end
            if (take) begin
                e_line_data = rd_rsp_data;
                e_line_idx  = rd_rsp_mdata;
            end
            nxt = m_phase;
            if (m_phase == P_IDLE || m_phase == P_DONE)
                nxt = start ? ((new_total == 0) ? P_DONE : P_REQ) : P_IDLE;
            else if (m_phase == P_REQ && m_issued == m_total)
                nxt = P_DRAIN;
            else if (m_phase == P_DRAIN && m_recv == m_total)
                nxt = P_DONE;
            if (issue) begin m_next = m_next + 42'd1; m_issued++; end
            if (take) m_recv++;
            if (start) begin
                m_total = new_total; m_next = hc_buf_addr; m_issued = 0; m_recv = 0;
                e_complete = 0;
            end
            if (nxt == P_DONE) e_complete = 1;
            m_phase = nxt;
            m_prev  = hc_control;
        end
    end

    // ---------------- monitor / compare ----------------
    int            req_cnt = 0, line_cnt = 0, done_cnt = 0, first_req_cyc = -1, done_cyc = -1;
    logic [41:0]   addr_log[$];
    logic [MW-1:0] mdata_log[$];
    logic [MW-1:0] line_log[$];
    int            req_cyc_log[$];
    logic [MW-1:0] pend[$];

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(negedge clk);
        chk("busy", busy, (m_phase == P_REQ) || (m_phase == P_DRAIN));
        chk("done", done, m_phase == P_DONE);
        chk("complete", complete, e_complete);
        chk("req_valid", rd_req_valid, e_req_valid);
        if (e_req_valid) begin
            chk("req_addr", rd_req_addr, e_req_addr);
            chk("req_mdata", rd_req_mdata, e_req_mdata);
        end
        chk("line_valid", line_valid, e_line_valid);
        if (e_line_valid) begin
            chk("line_idx", line_idx, e_line_idx);
            n_cmp++;
            if (line_data !== e_line_data) begin
                n_err++;
                $display("FAIL line_data: got %h expected %h", line_data, e_line_data);
            end
        end
        if (reset) begin
            if (rd_req_valid) begin
                req_cnt++;
                addr_log.push_back(rd_req_addr);
                mdata_log.push_back(rd_req_mdata);
                req_cyc_log.push_back(cyc);
                pend.push_back(rd_req_mdata);
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (line_valid) begin
                line_cnt++;
                line_log.push_back(line_idx);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    int rsp_mode = 0;   // 0 manual, 1 in-order immediate, 2 random order/delay
    bit alm_rand = 0;
    bit scramble = 0;
    int start_cyc = 0;

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        rd_rsp_valid = 1'b0;
        if (alm_rand) rd_req_almfull = ($urandom_range(0, 3) == 0);
        if (scramble) begin
            hc_buf_addr = 42'({$urandom, $urandom});
            hc_buf_size = $urandom;
        end
        if (rsp_mode != 0 && pend.size() > 0 && (rsp_mode == 1 || $urandom_range(0, 1) == 0)) begin
            int k;
            k = (rsp_mode == 1) ? 0 : int'($urandom_range(0, pend.size() - 1));
            rd_rsp_mdata = pend[k];
            pend.delete(k);
            rd_rsp_data  = rnd512();
            rd_rsp_valid = 1'b1;
        end
    endtask

    task automatic respond(input logic [MW-1:0] tag);
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = tag;
        rd_rsp_data  = rnd512();
        step();
    endtask

    task automatic kick(input logic [41:0] a, input logic [31:0] s);
        hc_buf_addr = a;
        hc_buf_size = s;
        hc_control  = 32'h1;
        start_cyc   = cyc;
        step();
        hc_control  = 32'h0;
    endtask

    task automatic clr_logs();
        req_cnt = 0; line_cnt = 0; done_cnt = 0; first_req_cyc = -1; done_cyc = -1;
        addr_log.delete(); mdata_log.delete(); line_log.delete(); req_cyc_log.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin step(); n++; end
        chk(name, done_cnt > 0, 1);
        step(); step();
    endtask

    task automatic wait_reqs(input int target, input int budget);
        int n;
        n = 0;
        while (req_cnt < target && n < budget) begin step(); n++; end
        chk("req_wait", req_cnt >= target, 1);
    endtask

    initial begin
        logic [41:0] a;
        logic [31:0] s;
        int c0, c1, drop_cyc, lc;

        repeat (3) step();
        #1;
        chk("rst_req_valid", rd_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_complete", complete, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_req_addr", rd_req_addr, 0);
        step();
        reset = 1'b1;
        repeat (2) step();

        // basic in-order transfer
        clr_logs(); rsp_mode = 1;
        kick(42'h1000, 32'd256);
        wait_done("t1_done_seen", 100);
        chk("t1_req_cnt", req_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", addr_log[i], 42'h1000 + 42'(i));
            chk("t1_mdata", mdata_log[i], 16'(i));
            chk("t1_line_idx", line_log[i], 16'(i));
        end
        chk("t1_first_req_latency", 64'(first_req_cyc - start_cyc), 2);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_complete", complete, 1);
        chk("t1_busy", busy, 0);

        // rounding: 65 bytes = 2 lines
        clr_logs();
        a = 42'({$urandom, $urandom});
        kick(a, 32'd65);
        wait_done("t2_done_seen", 100);
        chk("t2_req_cnt", req_cnt, 2);
        chk("t2_addr0", addr_log[0], a);
        chk("t2_addr1", addr_log[1], a + 42'd1);

        // zero size
        clr_logs();
        kick(42'h1234, 32'd0);
        repeat (5) step();
        chk("t3_req_cnt", req_cnt, 0);
        chk("t3_done_pulses", done_cnt, 1);
        chk("t3_done_latency", 64'(done_cyc - start_cyc), 1);
        chk("t3_complete", complete, 1);

        // almost-full backpressure
        clr_logs();
        kick(42'h2000, 32'd640);
        wait_reqs(3, 50);
        rd_req_almfull = 1'b1;
        c0 = req_cnt;
        repeat (10) step();
        c1 = req_cnt;
        rd_req_almfull = 1'b0;
        drop_cyc = cyc;
        chk("t4_reqs_under_almfull", (c1 - c0) <= 1, 1);
        wait_done("t4_done_seen", 200);
        chk("t4_req_cnt", req_cnt, 10);
        chk("t4_resume_cycle", 64'(req_cyc_log[c1] - drop_cyc), 1);

        // outstanding limit
        clr_logs(); rsp_mode = 0; pend.delete();
        kick(42'h3000, 32'd640);
        repeat (20) step();
        chk("t5_stall_cnt", req_cnt, MAXO);
        respond(pend.pop_front());
        repeat (6) step();
        chk("t5_one_more", req_cnt, MAXO + 1);
        rsp_mode = 1;
        wait_done("t5_done_seen", 200);
        chk("t5_req_cnt", req_cnt, 10);
        chk("t5_line_cnt", line_cnt, 10);

        // out-of-order responses
        clr_logs(); rsp_mode = 0; pend.delete();
        kick(42'h4000, 32'd256);
        wait_reqs(4, 30);
        pend.delete();
        respond(16'd3); respond(16'd0); respond(16'd2);
        step(); step();
        chk("t6_no_early_done", done_cnt, 0);
        respond(16'd1);
        wait_done("t6_done_seen", 20);
        chk("t6_idx0", line_log[0], 3);
        chk("t6_idx1", line_log[1], 0);
        chk("t6_idx2", line_log[2], 2);
        chk("t6_idx3", line_log[3], 1);
        chk("t6_done_pulses", done_cnt, 1);
        repeat (3) step();
        lc = line_cnt;
        respond(16'd7);
        step(); step();
        chk("t6_spurious_dropped", line_cnt, lc);

        // async reset mid-transfer
        clr_logs(); rsp_mode = 1; pend.delete();
        kick(42'h5000, 32'd640);
        wait_reqs(2, 30);
        #3;
        reset = 1'b0;
        #1;
        chk("t7_rst_req_valid", rd_req_valid, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_line_valid", line_valid, 0);
        chk("t7_rst_req_addr", rd_req_addr, 0);
        chk("t7_rst_complete", complete, 0);
        rsp_mode = 0; pend.delete();
        step(); step();
        reset = 1'b1;
        lc = line_cnt;
        respond(16'd2);
        step(); step();
        chk("t7_late_rsp_dropped", line_cnt, lc);
        clr_logs(); rsp_mode = 1; pend.delete();
        kick(42'h6000, 32'd128);
        wait_done("t7_done_seen", 100);
        chk("t7_req_cnt", req_cnt, 2);
        chk("t7_complete", complete, 1);

        // start while busy is ignored
        clr_logs(); rsp_mode = 0; pend.delete();
        kick(42'h7000, 32'd256);
        repeat (3) step();
        hc_buf_addr = 42'h9000; hc_buf_size = 32'd640; hc_control = 32'h1;
        step();
        hc_control = 32'h0;
        rsp_mode = 1;
        wait_done("t8_done_seen", 100);
        chk("t8_req_cnt", req_cnt, 4);
        chk("t8_last_addr", addr_log[3], 42'h7003);

        // randomised transfers, with address wrap and random backpressure
        rsp_mode = 2; alm_rand = 1;
        for (int it = 0; it < 12; it++) begin
            clr_logs(); pend.delete();
            a = 42'({$urandom, $urandom});
            s = $urandom_range(0, 1200);
            if (it == 0) s = 32'd64;
            if (it == 1) s = 32'd1;
            if (it == 2) begin a = 42'h3FF_FFFF_FFFE; s = 32'd256; end
            kick(a, s);
            scramble = 1;
            wait_done("rand_done_seen", 3000);
            scramble = 0;
            chk("rand_req_cnt", req_cnt, (64'(s) + 63) / 64);
            chk("rand_line_cnt", line_cnt, (64'(s) + 63) / 64);
        end
        alm_rand = 0; rd_req_almfull = 1'b0; rsp_mode = 0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
